// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - sequential instruction fetch with prefetch FIFO and redirect flush
// Optional FETCH_PERF_EN adds a saturating count of consumed instructions on fetch_stats.
module inst_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
`ifdef FETCH_PERF_EN
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_stats
`else
    input  logic [31:0] redirect_pc
`endif
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          imem_req_q, imem_req_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] count_after;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   pc_d   [DEPTH];
    logic          accept;
    logic          push;
    logic          pop;

    // Fetch control: one outstanding request, a FIFO slot reserved before each issue.
    always_comb begin
        accept      = imem_req_q && imem_ready;
        pop         = (count_q != '0) && inst_ready && !redirect;
        push        = 1'b0;
        state_d     = state_q;
        fpc_d       = fpc_q;
        req_pc_d    = req_pc_q;
        count_after = count_q + CW'(1) - CW'(pop);

        if (accept) begin
            fpc_d    = fpc_q + 32'd4;
            req_pc_d = fpc_q;
        end
        if (redirect) begin
            fpc_d = redirect_pc & 32'hFFFF_FFFC;
        end

        case (state_q)
            S_IDLE: begin
                if (redirect || (count_q < DEPTH_C)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (accept) begin
                    state_d = redirect ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    push    = 1'b1;
                    state_d = (count_after < DEPTH_C) ? S_REQ : S_IDLE;
                end
            end
            S_DROP: begin
                // A response arriving with a fresh redirect still retires the stale request.
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        imem_req_d = (state_d == S_REQ);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        pc_d     = pc_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = imem_rdata;
                pc_d[wr_ptr_q]   = req_pc_q;
                wr_ptr_d         = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            imem_req_q <= 1'b0;
            fpc_q      <= RESET_PC;
            req_pc_q   <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= 32'h0;
                pc_q[i]   <= 32'h0;
            end
        end else begin
            state_q    <= state_d;
            imem_req_q <= imem_req_d;
            fpc_q      <= fpc_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            pc_q       <= pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stats_q, stats_d;

    always_comb begin
        stats_d = stats_q;
        if (pop && (stats_q != 32'hFFFF_FFFF)) begin
            stats_d = stats_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stats_q <= 32'h0;
        end else begin
            stats_q <= stats_d;
        end
    end

    assign fetch_stats = stats_q;
`endif

    assign imem_req   = imem_req_q;
    assign imem_addr  = fpc_q;
    assign inst_valid = (count_q != '0);
    assign inst_data  = data_q[rd_ptr_q];
    assign inst_pc    = pc_q[rd_ptr_q];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed and randomized bench for inst_fetch_unit against a stream-level model
module tb_inst_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_stats;
`endif

    always #5 clk = ~clk;

    inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
`ifdef FETCH_PERF_EN
        .redirect_pc (redirect_pc),
        .fetch_stats (fetch_stats)
`else
        .redirect_pc (redirect_pc)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    bit          mem_busy;
    bit          mem_stale;
    logic [31:0] mem_addr;
    int          mem_delay;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          ready_rand = 1'b0;
    int          good_resp;
    int          accepts = 0;
    int          pops;
    int          a0;
    logic [31:0] addr_log [$];
    logic [31:0] pop_log  [$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qget(input int which, input int k);
        if (which == 0) return (addr_log.size() > k) ? addr_log[k] : 32'hDEAD_BEEF;
        return (pop_log.size() > k) ? pop_log[k] : 32'hDEAD_BEEF;
    endfunction

    // One clock: drive inputs, judge the handshakes about to complete, advance the model.
    task automatic cycle(input bit in_rdy, input bit do_redir, input logic [31:0] rpc);
        bit          rv, stale_rv, acc, pp, req_was;
        logic [31:0] a_addr;
        rv          = mem_busy && (mem_delay == 0);
        stale_rv    = rv && mem_stale;
        imem_rvalid = rv;
        imem_rdata  = rv ? word_of(mem_addr) : $urandom();
        imem_ready  = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        inst_ready  = in_rdy;
        redirect    = do_redir;
        redirect_pc = rpc;
        req_was     = imem_req;
        a_addr      = imem_addr;
        acc         = imem_req && imem_ready;
        pp          = inst_valid && in_rdy && !do_redir;
        if (acc) begin
            chk("one_outstanding", 32'(mem_busy), 32'd0);
            chk("req_addr", imem_addr, exp_fetch);
        end
        if (pp) begin
            chk("pop_pc", inst_pc, exp_pc);
            chk("pop_data", inst_data, word_of(exp_pc));
            pop_log.push_back(inst_pc);
            exp_pc += 32'd4;
            pops++;
        end
        @(posedge clk);
        #1;
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        if (rv) begin
            mem_busy = 1'b0;
            if (!mem_stale) good_resp++;
        end else if (mem_busy) begin
            mem_delay--;
        end
        if (acc) begin
            mem_busy  = 1'b1;
            mem_stale = 1'b0;
            mem_addr  = a_addr;
            mem_delay = $urandom_range(lat_max - 1, lat_min - 1);
            exp_fetch += 32'd4;
            accepts++;
            addr_log.push_back(a_addr);
        end
        if (do_redir) begin
            exp_fetch = rpc & 32'hFFFF_FFFC;
            exp_pc    = rpc & 32'hFFFF_FFFC;
            mem_stale = mem_busy;
            good_resp = 0;
            addr_log.delete();
            pop_log.delete();
            chk("flush_valid", 32'(inst_valid), 32'd0);
        end else begin
            if (rv && !stale_rv) chk("valid_after_push", 32'(inst_valid), 32'd1);
            if (req_was && !acc) begin
                chk("req_hold", 32'(imem_req), 32'd1);
                chk("addr_hold", imem_addr, a_addr);
            end
        end
`ifdef FETCH_PERF_EN
        chk("fetch_stats", fetch_stats, 32'(pops));
`endif
    endtask

    // Called one time unit after a rising edge; reset is applied and checked between edges.
    task automatic do_reset();
        rst         = 1'b0;
        imem_rvalid = 1'b0;
        imem_ready  = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        #2;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_data", inst_data, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
`ifdef FETCH_PERF_EN
        chk("rst_stats", fetch_stats, 32'd0);
`endif
        mem_busy  = 1'b0;
        mem_stale = 1'b0;
        exp_fetch = RPC;
        exp_pc    = RPC;
        pops      = 0;
        good_resp = 0;
        addr_log.delete();
        pop_log.delete();
        #2;
        rst = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Startup with zero-wait memory and an always-ready consumer.
        for (int i = 0; i < 3; i++) begin
            chk("startup_valid_low", 32'(inst_valid), 32'd0);
            cycle(1'b1, 1'b0, 32'h0);
        end
        repeat (16) cycle(1'b1, 1'b0, 32'h0);
        chk("startup_first_addr", qget(0, 0), 32'h100);
        chk("startup_pc0", qget(1, 0), 32'h100);
        chk("startup_pc1", qget(1, 1), 32'h104);
        chk("startup_pc2", qget(1, 2), 32'h108);

        // Backpressure: a stalled consumer allows exactly DEPTH fetches.
        cycle(1'b0, 1'b1, 32'h400);
        a0 = accepts;
        repeat (20) cycle(1'b0, 1'b0, 32'h0);
        chk("bp_accepts", 32'(accepts - a0), 32'(DEPTH));
        chk("bp_req_low", 32'(imem_req), 32'd0);
        repeat (14) cycle(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) chk("bp_pop_order", qget(1, k), 32'h400 + 32'(4 * k));

        // Redirect while a slow response is outstanding.
        lat_min = 4;
        lat_max = 4;
        for (int i = 0; i < 50 && !(mem_busy && mem_delay > 0 && !mem_stale); i++) cycle(1'b1, 1'b0, 32'h0);
        chk("wait_slow_resp", 32'(mem_busy && mem_delay > 0 && !mem_stale), 32'd1);
        cycle(1'b1, 1'b1, 32'h2003);
        repeat (30) cycle(1'b1, 1'b0, 32'h0);
        chk("redir_wait_addr", qget(0, 0), 32'h2000);
        chk("redir_wait_pc", qget(1, 0), 32'h2000);

        // Redirect coinciding with a pop and a returning response, two entries buffered.
        lat_min = 1;
        lat_max = 1;
        cycle(1'b0, 1'b1, 32'h3000);
        for (int i = 0; i < 40 && !(good_resp == 2 && mem_busy && mem_delay == 0 && !mem_stale); i++)
            cycle(1'b0, 1'b0, 32'h0);
        chk("wait_two_buffered", 32'(good_resp == 2 && mem_busy && mem_delay == 0), 32'd1);
        chk("two_buffered_valid", 32'(inst_valid), 32'd1);
        cycle(1'b1, 1'b1, 32'h5000);
        repeat (12) cycle(1'b1, 1'b0, 32'h0);
        chk("redir_collide_pc", qget(1, 0), 32'h5000);

        // Address wrap at the top of the address space.
        cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (12) cycle(1'b1, 1'b0, 32'h0);
        chk("wrap_addr0", qget(0, 0), 32'hFFFF_FFF8);
        chk("wrap_addr1", qget(0, 1), 32'hFFFF_FFFC);
        chk("wrap_addr2", qget(0, 2), 32'h0000_0000);

        // Randomized traffic: memory stalls, variable latency, consumer stalls, redirects.
        ready_rand = 1'b1;
        lat_min    = 1;
        lat_max    = 4;
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, $urandom());
        end

        // Reset in the middle of a fetch with three entries buffered.
        ready_rand = 1'b0;
        lat_min    = 3;
        lat_max    = 3;
        cycle(1'b0, 1'b1, 32'h6000);
        for (int i = 0; i < 60 && !(good_resp == 3 && mem_busy && !mem_stale); i++) cycle(1'b0, 1'b0, 32'h0);
        chk("wait_three_buffered", 32'(good_resp == 3 && mem_busy && !mem_stale), 32'd1);
        do_reset();
        lat_min = 1;
        lat_max = 1;
        repeat (12) cycle(1'b1, 1'b0, 32'h0);
        chk("restart_addr", qget(0, 0), RPC);
        chk("restart_pc", qget(1, 0), RPC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
